// File: rtl/spi_fifo_master_if.sv
// ---------------------------------------------------------------------------
// spi_fifo_master_if
//   Bundle of every non-clock signal of spi_fifo_master: the register-block
//   side (TX push, RX pop, status) and the SPI pins.
//
//   Parameter: DEPTH  FIFO entries per direction (sets count widths).
//
//   Handshake semantics: wr_en and rd_en are single-cycle strobes with no
//   ready back-pressure. A push is taken when wr_en is high and the TX FIFO
//   is not full (or is popped in the same cycle); otherwise the word is
//   dropped and overflow is set. A pop is taken when rd_en is high and
//   rx_empty is low; rd_data always shows the RX head (first-word-fall-
//   through, zero when empty).
//
//   Modports:
//     master : the side that owns the FIFO strobes (register block) and also
//              drives miso (the attached SPI device).
//     slave  : spi_fifo_master itself.
// ---------------------------------------------------------------------------
interface spi_fifo_master_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [15:0]   wr_data;
    logic          width_16;
    logic          rd_en;
    logic [15:0]   rd_data;
    logic          tx_full;
    logic          rx_empty;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic          overflow;
    logic          clear_err;
    logic          busy;
    logic          sclk;
    logic          mosi;
    logic          cs_n;
    logic          miso;

    modport master (
        output wr_en, wr_data, width_16, rd_en, clear_err, miso,
        input  rd_data, tx_full, rx_empty, tx_count, rx_count, overflow,
               busy, sclk, mosi, cs_n
    );

    modport slave (
        input  wr_en, wr_data, width_16, rd_en, clear_err, miso,
        output rd_data, tx_full, rx_empty, tx_count, rx_count, overflow,
               busy, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_fifo_master.sv
// ---------------------------------------------------------------------------
// spi_fifo_master
//   SPI mode-0 master with TX and RX FIFOs. Words (8 or 16 bit, width chosen
//   per push) are shifted out MSB first, back-to-back while the TX FIFO has
//   data, with cs_n held low across the burst. Each received word is queued
//   in the RX FIFO (8-bit words zero-extended).
//
//   Parameters:
//     DEPTH    FIFO entries per direction, power of 2, >= 2
//     CLK_DIV  raw_clk cycles per SCLK half-period, >= 1
//
//   Ports:
//     raw_clk    system clock, all logic on posedge
//     reset_n    asynchronous active-low reset
//     bus        spi_fifo_master_if.slave (FIFO strobes, status, SPI pins)
//     state_dbg  current FSM state encoding, for observation only
//
//   Build option:
//     SPI_LOOPBACK_EN  when defined the receive shifter samples the driven
//                      mosi value instead of the miso pin; sclk/mosi/cs_n
//                      still drive the pins.
// ---------------------------------------------------------------------------
module spi_fifo_master #(
    parameter int DEPTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                  raw_clk,
    input  logic                  reset_n,
    spi_fifo_master_if.slave      bus,
    output logic [2:0]            state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_HIGH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state;

    // ---------------- TX FIFO: entry = {width_16, data} ----------------
    logic [16:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wr, tx_rd;
    logic [CW-1:0] tx_cnt;
    logic          tx_full_i, tx_push, tx_pop, tx_drop;

    // ---------------- RX FIFO ----------------
    logic [15:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wr, rx_rd;
    logic [CW-1:0] rx_cnt;
    logic          rx_full_i, rx_empty_i, rx_push, rx_pop, rx_drop;

    // ---------------- shift engine ----------------
    logic [15:0]   tx_sh, rx_sh;
    logic [4:0]    bits;
    logic [DW-1:0] div_cnt;
    logic          cur_w16;
    logic          sclk_q, mosi_q, cs_q, ovf_q;
    logic [16:0]   tx_head;
    logic [15:0]   load_word;
    logic [15:0]   rx_word;
    logic          sample;

    assign tx_full_i  = (tx_cnt == FULL_CNT);
    assign rx_full_i  = (rx_cnt == FULL_CNT);
    assign rx_empty_i = (rx_cnt == '0);

    // LOAD is only entered with a non-empty TX FIFO and nothing else pops it,
    // so the pop needs no extra qualification.
    assign tx_pop  = (state == S_LOAD);
    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign tx_push = bus.wr_en && (!tx_full_i || tx_pop);
    assign tx_drop = bus.wr_en && tx_full_i && !tx_pop;

    assign rx_pop  = bus.rd_en && !rx_empty_i;
    assign rx_push = (state == S_DONE) && (!rx_full_i || rx_pop);
    assign rx_drop = (state == S_DONE) && rx_full_i && !rx_pop;

    assign tx_head   = tx_mem[tx_rd];
    // 8-bit words are left-aligned so the MSB is always tx_sh[15].
    assign load_word = tx_head[16] ? tx_head[15:0] : {tx_head[7:0], 8'h00};
    // For 8-bit words only the last eight sampled bits belong to this word.
    assign rx_word   = cur_w16 ? rx_sh : {8'h00, rx_sh[7:0]};

`ifdef SPI_LOOPBACK_EN
    assign sample = mosi_q;
`else
    assign sample = bus.miso;
`endif

    // FIFO storage carries no reset: an entry is only read after being written.
    always_ff @(posedge raw_clk) begin
        if (tx_push) tx_mem[tx_wr] <= {bus.width_16, bus.wr_data};
        if (rx_push) rx_mem[rx_wr] <= rx_word;
    end

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            unique case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: ;
            endcase

            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            unique case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: ;
            endcase

            // A new error wins over clear_err in the same cycle.
            if (tx_drop || rx_drop) ovf_q <= 1'b1;
            else if (bus.clear_err) ovf_q <= 1'b0;
        end
    end

    // Transfer FSM; all pin outputs are registered here.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bits    <= '0;
            div_cnt <= '0;
            cur_w16 <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (tx_cnt != '0) state <= S_LOAD;
                end
                S_LOAD: begin
                    tx_sh   <= load_word;
                    mosi_q  <= load_word[15];
                    cur_w16 <= tx_head[16];
                    bits    <= tx_head[16] ? 5'd16 : 5'd8;
                    cs_q    <= 1'b0;
                    div_cnt <= DIV_LAST;
                    state   <= S_SETUP;
                end
                S_SETUP: begin
                    if (div_cnt == '0) begin
                        // Rising edge: sample in the same cycle sclk goes high.
                        sclk_q  <= 1'b1;
                        rx_sh   <= {rx_sh[14:0], sample};
                        div_cnt <= DIV_LAST;
                        state   <= S_HIGH;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (div_cnt == '0) begin
                        sclk_q <= 1'b0;
                        bits   <= bits - 5'd1;
                        if (bits == 5'd1) begin
                            state <= S_DONE;
                        end else begin
                            tx_sh   <= {tx_sh[14:0], 1'b0};
                            mosi_q  <= tx_sh[14];
                            div_cnt <= DIV_LAST;
                            state   <= S_SETUP;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    // RX push happens combinationally in this state.
                    if (tx_cnt != '0) begin
                        state <= S_LOAD;
                    end else begin
                        cs_q  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_data  = rx_empty_i ? 16'h0000 : rx_mem[rx_rd];
    assign bus.tx_full  = tx_full_i;
    assign bus.rx_empty = rx_empty_i;
    assign bus.tx_count = tx_cnt;
    assign bus.rx_count = rx_cnt;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state != S_IDLE) || (tx_cnt != '0);
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs_n     = cs_q;
    assign state_dbg    = state;

endmodule
